// File: rtl/jtframe_rom_arb.sv
// jtframe_rom_arb
// Shares the board's single SDRAM read port between SLOTS game-side ROM
// clients. Each slot keeps its last fetched 32-bit word plus an address tag,
// so repeated reads of the same address are answered locally. Misses are
// granted round-robin, starting after the slot that was served last.
//
// Ports
//   clk_rom      SDRAM-domain clock (rising edge)
//   rst          asynchronous active-high reset
//   slot_req     per-slot level request
//   slot_addr    per-slot word address, slot i at [i*AW +: AW]
//   slot_ok      per-slot "slot_dout holds the word at slot_addr"
//   slot_dout    per-slot cached word, slot i at [i*32 +: 32]
//   sdram_req    read request to the SDRAM controller, held until ack
//   sdram_addr   address of the outstanding request
//   sdram_ack    one-cycle pulse, request accepted
//   data_read    SDRAM read data
//   data_rdy     one-cycle pulse, data_read valid
//   downloading  ROM download in progress (flushes the cache)
//   loop_rst     SDRAM controller re-initialising (flushes the cache)
//   busy         a fetch is in flight
module jtframe_rom_arb #(
    parameter int SLOTS = 4,
    parameter int AW    = 22
) (
    input  logic                clk_rom,
    input  logic                rst,
    input  logic [SLOTS-1:0]    slot_req,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*32-1:0] slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic [31:0]         data_read,
    input  logic                data_rdy,
    input  logic                downloading,
    input  logic                loop_rst,
    output logic                busy
);
    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]    last_q, last_d;
    logic             req_q, req_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [SLOTS-1:0] valid_q, valid_d;
    logic [SLOTS-1:0] ok_q, ok_d;
    logic [AW-1:0]    tag_q  [SLOTS];
    logic [AW-1:0]    tag_d  [SLOTS];
    logic [31:0]      data_q [SLOTS];
    logic [31:0]      data_d [SLOTS];

    logic [AW-1:0]    addr_a [SLOTS];
    logic [SLOTS-1:0] hit, pending;
    logic             flush, found, fill;
    logic [IW-1:0]    sel, idx;

    assign flush = downloading | loop_rst;

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            addr_a[i]  = slot_addr[i*AW +: AW];
            hit[i]     = slot_req[i] & valid_q[i] & (tag_q[i] == addr_a[i]);
            pending[i] = slot_req[i] & ~hit[i];
        end
    end

    // Round-robin search: first pending slot at last+1, last+2, ... mod SLOTS.
    always_comb begin
        found = 1'b0;
        sel   = last_q;
        idx   = '0;
        for (int k = 1; k <= SLOTS; k++) begin
            int j;
            j = int'(last_q) + k;
            if (j >= SLOTS) j = j - SLOTS;
            idx = IW'(j);
            if (!found && pending[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        req_d   = req_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        fill    = 1'b0;
        ok_d    = hit & {SLOTS{~flush}};

        if (flush) begin
            // Abandon any fetch; a late data_rdy finds the FSM in IDLE.
            state_d = IDLE;
            req_d   = 1'b0;
            valid_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        gnt_d   = sel;
                        addr_d  = addr_a[sel];
                        req_d   = 1'b1;
                        state_d = WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        req_d = 1'b0;
                        // Data may arrive together with the ack.
                        if (data_rdy) fill = 1'b1;
                        else          state_d = WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (data_rdy) fill = 1'b1;
                end
                default: state_d = IDLE;
            endcase

            // The tag is the issued address, even if the slot moved on since.
            if (fill) begin
                data_d[gnt_q]  = data_read;
                tag_d[gnt_q]   = addr_q;
                valid_d[gnt_q] = 1'b1;
                last_d         = gnt_q;
                state_d        = IDLE;
            end
        end
    end

    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(SLOTS-1);
            req_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= '0;
            ok_q    <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            ok_q    <= ok_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        for (int i = 0; i < SLOTS; i++) slot_dout[i*32 +: 32] = data_q[i];
    end

    assign slot_ok    = ok_q;
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;
    assign busy       = (state_q != IDLE);

endmodule
